// File: rtl/gpio_cfg_pkg.sv
// Shared configuration-word layout for the GPIO pad controller.
package gpio_cfg_pkg;

   localparam int CFG_W = 13;

   // Bit positions of each field inside the 13-bit configuration word
   localparam int MGMT_ENA_BIT  = 0;
   localparam int OUT_DIS_BIT   = 1;
   localparam int HOLDOVER_BIT  = 2;
   localparam int INP_DIS_BIT   = 3;
   localparam int IB_MODE_BIT   = 4;
   localparam int ANA_EN_BIT    = 5;
   localparam int ANA_SEL_BIT   = 6;
   localparam int ANA_POL_BIT   = 7;
   localparam int SLOW_SEL_BIT  = 8;
   localparam int VTRIP_SEL_BIT = 9;
   localparam int DM_LSB        = 10;
   localparam int DM_MSB        = 12;

   // Power-up configuration: management owns the pad, output disabled, dm=001
   localparam logic [CFG_W-1:0] DEFAULT_CFG = 13'h0403;

   // Shift counter: a load is only accepted after exactly CNT_FULL shifts
   localparam int               CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_FULL = 4'd13;
   localparam logic [CNT_W-1:0] CNT_MAX  = 4'd15;

   // Extract the three drive-mode bits from a configuration word
   function automatic logic [2:0] cfgDm(input logic [CFG_W-1:0] cfg);
      return cfg[DM_MSB:DM_LSB];
   endfunction

endpackage

// File: rtl/gpio_cfg_shift.sv
// Serial configuration chain stage: shift register, bit counter, shadow
// register and sticky length-error flag.
module gpio_cfg_shift
   import gpio_cfg_pkg::*;
#(
   parameter logic [CFG_W-1:0] RESET_CFG = DEFAULT_CFG
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             serial_data_i,
   input  logic             shift_en_i,
   input  logic             load_i,
   output logic             serial_data_o,
   output logic             cfg_err_o,
   output logic [CFG_W-1:0] shadow_o
);

   logic [CFG_W-1:0] shift_reg_q, shift_reg_d;
   logic [CFG_W-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Next-state logic; a load always sees the pre-shift register and count
   always_comb begin
      shift_reg_d = shift_reg_q;
      shadow_d    = shadow_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      if (shift_en_i) begin
         shift_reg_d = {shift_reg_q[CFG_W-2:0], serial_data_i};
      end
      if (load_i) begin
         if (cnt_q == CNT_FULL) begin
            shadow_d = shift_reg_q;
         end else begin
            err_d = 1'b1;
         end
         cnt_d = shift_en_i ? 4'd1 : 4'd0;
      end else if (shift_en_i && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 4'd1;
      end
   end

   // State registers; reset restores the default configuration at once
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         shift_reg_q <= '0;
         shadow_q    <= RESET_CFG;
         cnt_q       <= '0;
         err_q       <= 1'b0;
      end else begin
         shift_reg_q <= shift_reg_d;
         shadow_q    <= shadow_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
      end
   end

   assign serial_data_o = shift_reg_q[CFG_W-1];
   assign cfg_err_o     = err_q;
   assign shadow_o      = shadow_q;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// GPIO pad controller: serially configured pad settings plus the
// management/user data-path mux between the core and the pad.
module gpio_pad_ctrl
   import gpio_cfg_pkg::*;
#(
   parameter logic [CFG_W-1:0] DEFAULT_CFG = gpio_cfg_pkg::DEFAULT_CFG
) (
   input  logic       clock,
   input  logic       resetb,
   input  logic       serial_data_in,
   input  logic       shift_en,
   input  logic       load,
   output logic       serial_data_out,
   output logic       cfg_err,
   input  logic       mgmt_gpio_out,
   input  logic       mgmt_gpio_oeb,
   output logic       mgmt_gpio_in,
   input  logic       user_gpio_out,
   input  logic       user_gpio_oeb,
   output logic       user_gpio_in,
   input  logic       pad_gpio_in,
   output logic       pad_gpio_out,
   output logic       pad_gpio_outenb,
   output logic       pad_gpio_holdover,
   output logic       pad_gpio_inenb,
   output logic       pad_gpio_ib_mode_sel,
   output logic       pad_gpio_analog_en,
   output logic       pad_gpio_analog_sel,
   output logic       pad_gpio_analog_pol,
   output logic       pad_gpio_slow_sel,
   output logic       pad_gpio_vtrip_sel,
   output logic [2:0] pad_gpio_dm
);

   logic [CFG_W-1:0] shadow;
   logic             mgmtEna;
   logic             outDis;

   gpio_cfg_shift #(
      .RESET_CFG (DEFAULT_CFG)
   ) u_shift (
      .clock         (clock),
      .resetb        (resetb),
      .serial_data_i (serial_data_in),
      .shift_en_i    (shift_en),
      .load_i        (load),
      .serial_data_o (serial_data_out),
      .cfg_err_o     (cfg_err),
      .shadow_o      (shadow)
   );

   assign mgmtEna = shadow[MGMT_ENA_BIT];
   assign outDis  = shadow[OUT_DIS_BIT];

   // Pad static settings come straight from the registered shadow word
   assign pad_gpio_holdover    = shadow[HOLDOVER_BIT];
   assign pad_gpio_inenb       = shadow[INP_DIS_BIT];
   assign pad_gpio_ib_mode_sel = shadow[IB_MODE_BIT];
   assign pad_gpio_analog_en   = shadow[ANA_EN_BIT];
   assign pad_gpio_analog_sel  = shadow[ANA_SEL_BIT];
   assign pad_gpio_analog_pol  = shadow[ANA_POL_BIT];
   assign pad_gpio_slow_sel    = shadow[SLOW_SEL_BIT];
   assign pad_gpio_vtrip_sel   = shadow[VTRIP_SEL_BIT];
   assign pad_gpio_dm          = cfgDm(shadow);

   // Data path: management or user side drives the pad, out_dis forces tristate
   assign pad_gpio_out    = mgmtEna ? mgmt_gpio_out : user_gpio_out;
   assign pad_gpio_outenb = outDis ? 1'b1 : (mgmtEna ? mgmt_gpio_oeb : user_gpio_oeb);
   assign mgmt_gpio_in    = pad_gpio_in;
   assign user_gpio_in    = pad_gpio_in & ~mgmtEna;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench: two chained pad controllers against a behavioural model.
module tb_gpio_pad_ctrl;

   logic clock = 1'b0;
   logic resetb;
   logic sdi, shiftEn, load;

   logic       mgmtOut [2], mgmtOeb [2], userOut [2], userOeb [2], padIn [2];
   logic       sdo [2], cfgErr [2], mgmtIn [2], userIn [2], padOut [2], padOutenb [2];
   logic       holdover [2], inenb [2], ibMode [2], anaEn [2], anaSel [2], anaPol [2];
   logic       slowSel [2], vtrip [2];
   logic [2:0] dm [2];

   int mShift [2], mCnt [2], mShadow [2], mErr [2];
   int assertCount = 0;
   int failCount   = 0;

   // Free-running system clock
   always #5 clock = ~clock;

   gpio_pad_ctrl u0 (
      .clock(clock), .resetb(resetb), .serial_data_in(sdi), .shift_en(shiftEn), .load(load),
      .serial_data_out(sdo[0]), .cfg_err(cfgErr[0]),
      .mgmt_gpio_out(mgmtOut[0]), .mgmt_gpio_oeb(mgmtOeb[0]), .mgmt_gpio_in(mgmtIn[0]),
      .user_gpio_out(userOut[0]), .user_gpio_oeb(userOeb[0]), .user_gpio_in(userIn[0]),
      .pad_gpio_in(padIn[0]), .pad_gpio_out(padOut[0]), .pad_gpio_outenb(padOutenb[0]),
      .pad_gpio_holdover(holdover[0]), .pad_gpio_inenb(inenb[0]), .pad_gpio_ib_mode_sel(ibMode[0]),
      .pad_gpio_analog_en(anaEn[0]), .pad_gpio_analog_sel(anaSel[0]), .pad_gpio_analog_pol(anaPol[0]),
      .pad_gpio_slow_sel(slowSel[0]), .pad_gpio_vtrip_sel(vtrip[0]), .pad_gpio_dm(dm[0])
   );

   gpio_pad_ctrl u1 (
      .clock(clock), .resetb(resetb), .serial_data_in(sdo[0]), .shift_en(shiftEn), .load(load),
      .serial_data_out(sdo[1]), .cfg_err(cfgErr[1]),
      .mgmt_gpio_out(mgmtOut[1]), .mgmt_gpio_oeb(mgmtOeb[1]), .mgmt_gpio_in(mgmtIn[1]),
      .user_gpio_out(userOut[1]), .user_gpio_oeb(userOeb[1]), .user_gpio_in(userIn[1]),
      .pad_gpio_in(padIn[1]), .pad_gpio_out(padOut[1]), .pad_gpio_outenb(padOutenb[1]),
      .pad_gpio_holdover(holdover[1]), .pad_gpio_inenb(inenb[1]), .pad_gpio_ib_mode_sel(ibMode[1]),
      .pad_gpio_analog_en(anaEn[1]), .pad_gpio_analog_sel(anaSel[1]), .pad_gpio_analog_pol(anaPol[1]),
      .pad_gpio_slow_sel(slowSel[1]), .pad_gpio_vtrip_sel(vtrip[1]), .pad_gpio_dm(dm[1])
   );

   function automatic int bitOf(input int v, input int k);
      return (v >> k) & 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic randomizeInputs();
      for (int i = 0; i < 2; i++) begin
         mgmtOut[i] = 1'($urandom_range(0, 1));
         mgmtOeb[i] = 1'($urandom_range(0, 1));
         userOut[i] = 1'($urandom_range(0, 1));
         userOeb[i] = 1'($urandom_range(0, 1));
         padIn[i]   = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mShift[i]  = 0;
         mCnt[i]    = 0;
         mShadow[i] = 'h0403;
         mErr[i]    = 0;
      end
   endtask

   // One clock edge of the chain: instance 1 receives instance 0's old top bit
   task automatic modelStep(input int b, input int sh, input int ld);
      int bIn [2];
      bIn[0] = b;
      bIn[1] = bitOf(mShift[0], 12);
      for (int i = 0; i < 2; i++) begin
         if (ld != 0) begin
            if (mCnt[i] == 13) mShadow[i] = mShift[i];
            else               mErr[i] = 1;
         end
         if (sh != 0) mShift[i] = (mShift[i] * 2 + bIn[i]) % 8192;
         if (ld != 0)                      mCnt[i] = (sh != 0) ? 1 : 0;
         else if (sh != 0 && mCnt[i] < 15) mCnt[i] = mCnt[i] + 1;
      end
   endtask

   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         string pre;
         int    s, mEna, oDis;
         pre  = $sformatf("u%0d", i);
         s    = mShadow[i];
         mEna = bitOf(s, 0);
         oDis = bitOf(s, 1);
         checkOutput({pre, "_sdo"},      32'(sdo[i]),      32'(bitOf(mShift[i], 12)));
         checkOutput({pre, "_cfg_err"},  32'(cfgErr[i]),   32'(mErr[i]));
         checkOutput({pre, "_holdover"}, 32'(holdover[i]), 32'(bitOf(s, 2)));
         checkOutput({pre, "_inenb"},    32'(inenb[i]),    32'(bitOf(s, 3)));
         checkOutput({pre, "_ib_mode"},  32'(ibMode[i]),   32'(bitOf(s, 4)));
         checkOutput({pre, "_ana_en"},   32'(anaEn[i]),    32'(bitOf(s, 5)));
         checkOutput({pre, "_ana_sel"},  32'(anaSel[i]),   32'(bitOf(s, 6)));
         checkOutput({pre, "_ana_pol"},  32'(anaPol[i]),   32'(bitOf(s, 7)));
         checkOutput({pre, "_slow"},     32'(slowSel[i]),  32'(bitOf(s, 8)));
         checkOutput({pre, "_vtrip"},    32'(vtrip[i]),    32'(bitOf(s, 9)));
         checkOutput({pre, "_dm"},       32'(dm[i]),       32'((s >> 10) & 7));
         checkOutput({pre, "_pad_out"},  32'(padOut[i]),   32'(mEna != 0 ? mgmtOut[i] : userOut[i]));
         checkOutput({pre, "_outenb"},   32'(padOutenb[i]),
                     32'(oDis != 0 ? 1'b1 : (mEna != 0 ? mgmtOeb[i] : userOeb[i])));
         checkOutput({pre, "_mgmt_in"},  32'(mgmtIn[i]),   32'(padIn[i]));
         checkOutput({pre, "_user_in"},  32'(userIn[i]),   32'(mEna != 0 ? 1'b0 : padIn[i]));
      end
   endtask

   // Drive one cycle of strobes, advance the model on the edge, check at the falling edge
   task automatic applyStimulus(input logic b, input logic sh, input logic ld);
      sdi     = b;
      shiftEn = sh;
      load    = ld;
      @(posedge clock);
      modelStep(int'(b), int'(sh), int'(ld));
      @(negedge clock);
      shiftEn = 1'b0;
      load    = 1'b0;
      randomizeInputs();
      #1;
      checkAll();
   endtask

   task automatic shiftWord(input int w, input int n);
      for (int k = n - 1; k >= 0; k--) applyStimulus(1'(bitOf(w, k)), 1'b1, 1'b0);
   endtask

   // Asynchronous reset mid-cycle: state must clear before any clock edge
   task automatic applyReset();
      resetb  = 1'b0;
      shiftEn = 1'b0;
      load    = 1'b0;
      #1;
      modelReset();
      randomizeInputs();
      #1;
      checkAll();
      @(negedge clock);
      #1;
      resetb = 1'b1;
      #1;
      checkAll();
   endtask

   initial begin
      resetb  = 1'b0;
      sdi     = 1'b0;
      shiftEn = 1'b0;
      load    = 1'b0;
      randomizeInputs();
      modelReset();
      @(negedge clock);
      #1;
      checkAll();
      checkOutput("rst_dm",      32'(dm[0]),        32'd1);
      checkOutput("rst_outenb",  32'(padOutenb[0]), 32'd1);
      checkOutput("rst_user_in", 32'(userIn[0]),    32'd0);
      checkOutput("rst_mgmt_in", 32'(mgmtIn[0]),    32'(padIn[0]));
      resetb = 1'b1;

      // Good load of 13'h1C00: user side takes over the pad, dm=111
      shiftWord('h1C00, 13);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("good_dm",      32'(dm[0]),     32'd7);
      checkOutput("good_err",     32'(cfgErr[0]), 32'd0);
      checkOutput("good_pad_out", 32'(padOut[0]), 32'(userOut[0]));

      // Short load: shadow kept, error sticky even across a later good load
      shiftWord('h0403, 12);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("short_err", 32'(cfgErr[0]), 32'd1);
      checkOutput("short_dm",  32'(dm[0]),     32'd7);
      shiftWord('h0403, 13);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("sticky_err", 32'(cfgErr[0]), 32'd1);

      // Simultaneous strobes: pre-shift word loads and counting restarts at 1
      applyReset();
      shiftWord('h1C00, 13);
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("simul_dm",  32'(dm[0]),     32'd7);
      checkOutput("simul_err", 32'(cfgErr[0]), 32'd0);
      shiftWord('h0403, 12);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("simul_next_dm",  32'(dm[0]),     32'd5);
      checkOutput("simul_next_err", 32'(cfgErr[0]), 32'd0);

      // Chain of two: the counter saturates, so each 13-bit word gets its own load
      applyReset();
      shiftWord('h0403, 13);
      applyStimulus(1'b0, 1'b0, 1'b1);
      shiftWord('h1C00, 13);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("chain_dm0",  32'(dm[0]),     32'd7);
      checkOutput("chain_dm1",  32'(dm[1]),     32'd1);
      checkOutput("chain_sdo1", 32'(sdo[1]),    32'd0);
      checkOutput("chain_err0", 32'(cfgErr[0]), 32'd0);
      checkOutput("chain_err1", 32'(cfgErr[1]), 32'd0);

      // Reset in the middle of a shift sequence, then a clean reload
      shiftWord('h1FFF, 7);
      applyReset();
      checkOutput("midrst_dm",  32'(dm[0]),  32'd1);
      checkOutput("midrst_sdo", 32'(sdo[0]), 32'd0);
      shiftWord('h1C00, 13);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("midrst_reload_dm",  32'(dm[0]),     32'd7);
      checkOutput("midrst_reload_err", 32'(cfgErr[0]), 32'd0);

      // Randomised bursts of 10..15 shifts ending in a load, a combined strobe or nothing
      for (int iter = 0; iter < 60; iter++) begin
         int n, w, mode;
         if (iter % 10 == 0) applyReset();
         n = $urandom_range(10, 15);
         w = int'($urandom_range(0, 8191));
         for (int k = n - 1; k >= 0; k--) begin
            applyStimulus(1'(bitOf(w, k)), 1'b1, 1'b0);
            if ($urandom_range(0, 7) == 0) applyStimulus(1'($urandom_range(0, 1)), 1'b0, 1'b0);
         end
         mode = $urandom_range(0, 2);
         if (mode == 0)      applyStimulus(1'b0, 1'b0, 1'b1);
         else if (mode == 1) applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1);
         else                applyStimulus(1'b0, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
